aes128_encrypt_ctrl: RTL and testbench



---
 rtl/aes_pkg.sv | 92 +++++++++
 rtl/aes_key_expand_step.sv | 20 ++
 rtl/aes128_encrypt_ctrl.sv | 115 +++++++++++
 tb/tb_aes128_encrypt_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: controller states, round constants and the byte-level
// transforms used by the iterative round datapath and the key schedule.
package aes_pkg;

   localparam int AES_NR  = 10;
   localparam int BLOCK_W = 128;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ROUND = 2'd1,
      FINAL = 2'd2,
      DONE  = 2'd3
   } ctrlState_t;

   localparam logic [7:0] RCON [1:10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                          8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

   localparam logic [7:0] SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   // Rounds outside 1..10 carry no constant; the key path is unused then.
   function automatic logic [7:0] rconFor(input logic [3:0] r);
      if (r >= 4'd1 && r <= 4'd10) return RCON[r];
      else return 8'h00;
   endfunction

   function automatic logic [31:0] subWord(input logic [31:0] w);
      return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
   endfunction

   function automatic logic [127:0] subBytes(input logic [127:0] s);
      return {subWord(s[127:96]), subWord(s[95:64]), subWord(s[63:32]), subWord(s[31:0])};
   endfunction

   function automatic logic [127:0] shiftRows(input logic [127:0] s);
      logic [127:0] r;
      r = 128'h0;
      for (int c = 0; c < 4; c++) begin
         for (int row = 0; row < 4; row++) begin
            r[127 - 8*(4*c + row) -: 8] = s[127 - 8*(4*((c + row) % 4) + row) -: 8];
         end
      end
      return r;
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [127:0] mixColumns(input logic [127:0] s);
      logic [127:0] r;
      logic [7:0]   a0, a1, a2, a3;
      r = 128'h0;
      for (int c = 0; c < 4; c++) begin
         {a0, a1, a2, a3} = s[127 - 32*c -: 32];
         r[127 - 32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
      end
      return r;
   endfunction

   function automatic logic [127:0] addRoundKey(input logic [127:0] s, input logic [127:0] k);
      return s ^ k;
   endfunction

   function automatic logic [127:0] encryptRound(input logic [127:0] s, input logic [127:0] k);
      return addRoundKey(mixColumns(shiftRows(subBytes(s))), k);
   endfunction

   function automatic logic [127:0] finalRound(input logic [127:0] s, input logic [127:0] k);
      return addRoundKey(shiftRows(subBytes(s)), k);
   endfunction

endpackage

// File: rtl/aes_key_expand_step.sv
// One AES-128 key-schedule step: derives the next round key from the current one.
module aes_key_expand_step
   import aes_pkg::*;
(
   input  logic [127:0] rk,
   input  logic [7:0]   rcon,
   output logic [127:0] nrk
);

   logic [31:0] w0, w1, w2, w3;
   logic [31:0] n0, n1, n2, n3;

   assign {w0, w1, w2, w3} = rk;
   assign n0  = w0 ^ subWord({w3[23:0], w3[31:24]}) ^ {rcon, 24'h000000};
   assign n1  = w1 ^ n0;
   assign n2  = w2 ^ n1;
   assign n3  = w3 ^ n2;
   assign nrk = {n0, n1, n2, n3};

endmodule

// File: rtl/aes128_encrypt_ctrl.sv
// Iterative AES-128 encryptor: one round per clock on a shared round datapath, with the
// round key derived alongside; handshakes on both the plaintext and ciphertext sides.
module aes128_encrypt_ctrl
   import aes_pkg::*;
#(
   parameter int NUM_ROUNDS = 10
)(
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] plaintext,
   input  logic [127:0] key,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] ciphertext,
   output logic         busy,
   output logic [3:0]   round_idx
);

   if (NUM_ROUNDS != AES_NR) begin : gBadRounds
      $error("aes128_encrypt_ctrl supports only NUM_ROUNDS = 10");
   end

   ctrlState_t   stateQ, stateD;
   logic [127:0] blockQ, blockD;
   logic [127:0] rkQ, rkD;
   logic [127:0] ctQ, ctD;
   logic [3:0]   roundQ, roundD;
   logic         outValidQ, outValidD;
   logic [127:0] nextRk;
   logic         accept;

   aes_key_expand_step uKeyStep (
      .rk   (rkQ),
      .rcon (rconFor(roundQ)),
      .nrk  (nextRk)
   );

   // A consume in DONE frees the slot in the same cycle, so a new block can enter without a bubble.
   assign in_ready   = (stateQ == IDLE) | ((stateQ == DONE) & out_ready);
   assign accept     = in_valid & in_ready;
   assign busy       = (stateQ == ROUND) | (stateQ == FINAL);
   assign round_idx  = busy ? roundQ : 4'd0;
   assign out_valid  = outValidQ;
   assign ciphertext = ctQ;

   // Next-state, round datapath and handshake decisions.
   always_comb begin
      stateD    = stateQ;
      blockD    = blockQ;
      rkD       = rkQ;
      ctD       = ctQ;
      roundD    = roundQ;
      outValidD = outValidQ;
      case (stateQ)
         IDLE, DONE: begin
            if (accept) begin
               blockD    = addRoundKey(plaintext, key);
               rkD       = key;
               roundD    = 4'd1;
               outValidD = 1'b0;
               stateD    = ROUND;
            end else if ((stateQ == DONE) && !out_ready) begin
               stateD = DONE;
            end else begin
               outValidD = 1'b0;
               stateD    = IDLE;
            end
         end
         ROUND: begin
            blockD = encryptRound(blockQ, nextRk);
            rkD    = nextRk;
            roundD = roundQ + 4'd1;
            if (roundQ == 4'(NUM_ROUNDS - 1)) begin
               stateD = FINAL;
            end else begin
               stateD = ROUND;
            end
         end
         FINAL: begin
            ctD       = finalRound(blockQ, nextRk);
            rkD       = nextRk;
            roundD    = 4'd0;
            outValidD = 1'b1;
            stateD    = DONE;
         end
         default: begin
            roundD    = 4'd0;
            outValidD = 1'b0;
            stateD    = IDLE;
         end
      endcase
   end

   // State, datapath and result registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stateQ    <= IDLE;
         blockQ    <= 128'h0;
         rkQ       <= 128'h0;
         ctQ       <= 128'h0;
         roundQ    <= 4'd0;
         outValidQ <= 1'b0;
      end else begin
         stateQ    <= stateD;
         blockQ    <= blockD;
         rkQ       <= rkD;
         ctQ       <= ctD;
         roundQ    <= roundD;
         outValidQ <= outValidD;
      end
   end

endmodule

// File: tb/tb_aes128_encrypt_ctrl.sv
// Scoreboard bench for aes128_encrypt_ctrl: directed FIPS-197 vectors, handshake corner cases,
// mid-operation reset and random blocks checked against an independent GF(2^8) AES model.
module tb_aes128_encrypt_ctrl;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] plaintext;
   logic [127:0] key;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] ciphertext;
   logic         busy;
   logic [3:0]   round_idx;

   localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;

   typedef struct {
      logic [127:0] ct;
      int           acceptEdge;
   } expEntry_t;

   expEntry_t  sb[$];
   int         checks = 0;
   int         failures = 0;
   int         cycle = 0;
   int         issued = 0;
   int         received = 0;
   logic       prevValid = 1'b0;
   logic [7:0] sboxT [256];

   aes128_encrypt_ctrl #(.NUM_ROUNDS(10)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .plaintext  (plaintext),
      .key        (key),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .ciphertext (ciphertext),
      .busy       (busy),
      .round_idx  (round_idx)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cycle <= cycle + 1;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] x = a;
      logic [7:0] y = b;
      for (int i = 0; i < 8; i++) begin
         if (y[0]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
         y = y >> 1;
      end
      return p;
   endfunction

   // S-box from the field inverse and affine map rather than a table.
   function automatic logic [7:0] sboxCalc(input logic [7:0] a);
      logic [7:0] inv = 8'h01;
      logic [7:0] r;
      if (a == 8'h00) inv = 8'h00;
      else for (int i = 0; i < 254; i++) inv = gmul(inv, a);
      r = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]};
      return r ^ 8'h63;
   endfunction

   function automatic logic [127:0] aesRef(input logic [127:0] pt, input logic [127:0] k);
      logic [7:0]   s [16];
      logic [7:0]   t [16];
      logic [31:0]  w [44];
      logic [31:0]  tmp;
      logic [7:0]   rc = 8'h01;
      logic [7:0]   a0, a1, a2, a3;
      logic [127:0] res = 128'h0;
      for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         tmp = w[i-1];
         if (i % 4 == 0) begin
            tmp = {sboxT[tmp[23:16]], sboxT[tmp[15:8]], sboxT[tmp[7:0]], sboxT[tmp[31:24]]} ^ {rc, 24'h0};
            rc  = gmul(rc, 8'h02);
         end
         w[i] = w[i-4] ^ tmp;
      end
      for (int i = 0; i < 16; i++) s[i] = pt[127 - 8*i -: 8] ^ w[i/4][31 - 8*(i%4) -: 8];
      for (int rnd = 1; rnd <= 10; rnd++) begin
         for (int i = 0; i < 16; i++) t[i] = sboxT[s[i]];
         for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) s[r + 4*c] = t[r + 4*((c + r) % 4)];
         if (rnd < 10) begin
            for (int c = 0; c < 4; c++) begin
               a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
               s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
               s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
               s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
               s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
            end
         end
         for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*rnd + i/4][31 - 8*(i%4) -: 8];
      end
      for (int i = 0; i < 16; i++) res[127 - 8*i -: 8] = s[i];
      return res;
   endfunction

   // Monitor: latency on first presentation, value every presented cycle, pop on consume.
   always @(negedge clk) begin
      if (!rst && out_valid) begin
         if (sb.size() == 0) begin
            if (!prevValid) check("unexpected_output", ciphertext, 128'h0 ^ {128{1'bx}});
         end else begin
            if (!prevValid) check("latency", 128'(cycle - sb[0].acceptEdge), 128'd10);
            check("ciphertext", ciphertext, sb[0].ct);
            if (out_ready) begin
               void'(sb.pop_front());
               received <= received + 1;
            end
         end
      end
      prevValid <= out_valid & ~rst;
   end

   task automatic drive(input logic [127:0] pt, input logic [127:0] k, input logic [127:0] ct,
                        output int acc);
      bit got = 1'b0;
      acc = -1;
      @(posedge clk); #1;
      in_valid = 1'b1; plaintext = pt; key = k;
      for (int i = 0; i < 300 && !got; i++) begin
         @(negedge clk);
         if (in_ready) begin
            got = 1'b1;
            acc = cycle + 1;
            sb.push_back('{ct, cycle + 1});
            issued++;
         end
      end
      if (!got) check("accept_timeout", 128'd0, 128'd1);
      @(posedge clk); #1;
      in_valid = 1'b0; plaintext = 128'h0; key = 128'h0;
   endtask

   task automatic waitDrain();
      for (int i = 0; i < 500 && sb.size() != 0; i++) @(negedge clk);
      check("drain", 128'(sb.size()), 128'd0);
   endtask

   task automatic checkResetOutputs(input string tag);
      check({tag, "_in_ready"}, 128'(in_ready), 128'd1);
      check({tag, "_out_valid"}, 128'(out_valid), 128'd0);
      check({tag, "_busy"}, 128'(busy), 128'd0);
      check({tag, "_round_idx"}, 128'(round_idx), 128'd0);
      check({tag, "_ciphertext"}, ciphertext, 128'h0);
   endtask

   initial begin
      int a1, a2;
      bit done;
      logic [127:0] rpt, rkey;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; plaintext = 128'h0; key = 128'h0;
      for (int i = 0; i < 256; i++) sboxT[i] = sboxCalc(8'(i));
      #2;
      checkResetOutputs("reset");
      check("model_c1", aesRef(C1_PT, C1_KEY), C1_CT);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // FIPS-197 C.1 with latency checked by the monitor.
      drive(C1_PT, C1_KEY, C1_CT, a1);
      waitDrain();

      // FIPS-197 appendix B with the round index walked.
      drive(B_PT, B_KEY, B_CT, a1);
      for (int r = 1; r <= 10; r++) begin
         @(negedge clk);
         check("round_idx", 128'(round_idx), 128'(r));
         check("busy_running", 128'(busy), 128'd1);
      end
      @(negedge clk);
      check("round_idx_done", 128'(round_idx), 128'd0);
      check("busy_done", 128'(busy), 128'd0);
      waitDrain();

      // Backpressure: result held 20 cycles, a new offer is ignored.
      @(posedge clk); #1 out_ready = 1'b0;
      drive(C1_PT, C1_KEY, C1_CT, a1);
      for (int i = 0; i < 30 && !out_valid; i++) @(negedge clk);
      @(posedge clk); #1;
      in_valid = 1'b1; plaintext = B_PT; key = B_KEY;
      repeat (20) begin
         @(negedge clk);
         check("held_out_valid", 128'(out_valid), 128'd1);
         check("held_in_ready", 128'(in_ready), 128'd0);
      end
      @(posedge clk); #1;
      in_valid = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("released_out_valid", 128'(out_valid), 128'd0);
      check("ignored_offer_busy", 128'(busy), 128'd0);
      check("queue_after_release", 128'(sb.size()), 128'd0);

      // Back-to-back: second block accepted in the DONE cycle.
      drive(C1_PT, C1_KEY, C1_CT, a1);
      drive(B_PT, B_KEY, B_CT, a2);
      check("b2b_gap", 128'(a2 - a1), 128'd11);
      waitDrain();

      // Reset during round 5 aborts without presenting a result.
      drive(C1_PT, C1_KEY, C1_CT, a1);
      repeat (4) @(posedge clk);
      #1 check("round_before_reset", 128'(round_idx), 128'd5);
      #2 rst = 1'b1;
      #1 checkResetOutputs("midreset");
      issued = issued - sb.size();
      sb.delete();
      @(negedge clk) rst = 1'b0;
      drive(B_PT, B_KEY, B_CT, a1);
      waitDrain();

      // Random blocks with random output stalls.
      done = 1'b0;
      fork
         begin
            for (int n = 0; n < 1000; n++) begin
               rpt  = {$urandom(), $urandom(), $urandom(), $urandom()};
               rkey = {$urandom(), $urandom(), $urandom(), $urandom()};
               drive(rpt, rkey, aesRef(rpt, rkey), a1);
            end
            waitDrain();
            done = 1'b1;
         end
         begin
            while (!done) begin
               @(posedge clk); #1 out_ready = ($urandom_range(0, 3) != 0);
            end
         end
      join
      out_ready = 1'b1;
      repeat (3) @(negedge clk);
      check("output_count", 128'(received), 128'(issued));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
